// File: rtl/sha_nonce_scheduler_pkg.sv
// Shared types and constants for the nonce scheduler and its found-nonce slot.
package sha_nonce_scheduler_pkg;

    localparam int NONCE_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/sha_found_slot.sv
// One-entry winner register: loads next cycle when empty or being drained the same cycle.
// Holds until i_rdy; a winner arriving while full is dropped and flagged in sticky o_ovf.
module sha_found_slot
    import sha_nonce_scheduler_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load_vld,
    input  logic [NONCE_W-1:0] i_load_dat,
    input  logic               i_clr_ovf,
    input  logic               i_rdy,
    output logic               o_vld,
    output logic [NONCE_W-1:0] o_dat,
    output logic               o_ovf
);

    logic               r_vld;
    logic [NONCE_W-1:0] r_dat;
    logic               r_ovf;
    logic               w_take;
    logic               w_accept;

    assign w_take   = r_vld && i_rdy;
    assign w_accept = i_load_vld && (!r_vld || w_take);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_vld <= 1'b0;
            r_dat <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dat <= i_load_dat;
                r_vld <= 1'b1;
            end else if (w_take) begin
                r_vld <= 1'b0;
            end
            // A lost winner outranks the clear so it is never silently hidden.
            if (i_load_vld && !w_accept) begin
                r_ovf <= 1'b1;
            end else if (i_clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign o_vld = r_vld;
    assign o_dat = r_dat;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/sha_nonce_scheduler.sv
// Feeds one pipelined double-SHA core: newblock beat, then one nonce per cycle; matches results.
// Job accepted -> first beat next cycle; hit -> found next cycle; beats never stall, slot overflows.
module sha_nonce_scheduler
    import sha_nonce_scheduler_pkg::*;
#(
    parameter logic [NONCE_W-1:0] PROCESSORINDEX = '0,
    parameter logic [NONCE_W-1:0] NUMPROCESSORS  = 32'd1,
    parameter int                 MAX_INFLIGHT   = 256
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_job_valid,
    output logic               o_job_ready,
    input  logic [NONCE_W-1:0] i_job_target,
    input  logic               i_abort,
    output logic               o_core_valid,
    output logic               o_core_newblock,
    output logic [NONCE_W-1:0] o_core_nonce,
    input  logic               i_res_valid,
    input  logic               i_res_newblock,
    input  logic [NONCE_W-1:0] i_res_hash_top,
    output logic               o_found_valid,
    input  logic               i_found_ready,
    output logic [NONCE_W-1:0] o_found_nonce,
    output logic               o_busy,
    output logic               o_overflow
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NONCE_W-1:0] r_nonce_ctr;
    logic [NONCE_W-1:0] r_target;
    logic [NONCE_W-1:0] r_ret_nonce;
    logic [CNT_W-1:0]   r_inflight;
    logic               r_job_ok;
    logic               r_synced;
    logic               r_abort_pend;

    logic               w_job_acc;
    logic               w_beat;
    logic               w_newblock;
    logic               w_abort_hon;
    logic               w_drain_done;
    logic               w_abort_now;
    logic [NONCE_W:0]   w_sum;
    logic [NONCE_W-1:0] w_res_nonce;
    logic               w_res_dec;
    logic               w_hit;

    assign w_sum     = {1'b0, r_nonce_ctr} + {1'b0, NUMPROCESSORS};
    assign w_job_acc = (r_state == ST_IDLE) && i_job_valid;

    always_comb begin
        w_state_nxt  = r_state;
        w_beat       = 1'b0;
        w_newblock   = 1'b0;
        w_abort_hon  = 1'b0;
        w_drain_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_job_valid) w_state_nxt = ST_START;
            end
            ST_START: begin
                w_beat      = 1'b1;
                w_newblock  = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (i_abort || r_abort_pend) begin
                    w_abort_hon = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_beat = 1'b1;
                    // Carry out means the next nonce would wrap: this beat is the last one.
                    if (w_sum[NONCE_W]) w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_inflight == '0 && !i_res_valid) begin
                    w_drain_done = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_abort_now = ((r_state == ST_START) && i_abort) || w_abort_hon;
    assign w_res_nonce = i_res_newblock ? PROCESSORINDEX : r_ret_nonce;
    assign w_res_dec   = i_res_valid && (r_inflight != '0);
    // Results only count once this job's newblock has come back and the job was not aborted.
    assign w_hit       = i_res_valid && r_job_ok && (i_res_newblock || r_synced)
                         && (i_res_hash_top <= r_target);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= ST_IDLE;
            r_nonce_ctr  <= '0;
            r_target     <= '0;
            r_ret_nonce  <= '0;
            r_inflight   <= '0;
            r_job_ok     <= 1'b0;
            r_synced     <= 1'b0;
            r_abort_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_abort_pend <= (r_state == ST_START) && i_abort;
            if (w_job_acc) begin
                r_target    <= i_job_target;
                r_nonce_ctr <= PROCESSORINDEX;
            end else if (w_beat) begin
                r_nonce_ctr <= w_sum[NONCE_W-1:0];
            end
            if (w_job_acc) begin
                r_job_ok <= 1'b1;
            end else if (w_abort_now || w_drain_done) begin
                r_job_ok <= 1'b0;
            end
            if (w_job_acc) begin
                r_synced <= 1'b0;
            end else if (i_res_valid && i_res_newblock) begin
                r_synced <= 1'b1;
            end
            if (i_res_valid) r_ret_nonce <= w_res_nonce + NUMPROCESSORS;
            if (w_beat && !w_res_dec) begin
                if (r_inflight < CNT_W'(MAX_INFLIGHT)) r_inflight <= r_inflight + 1'b1;
            end else if (!w_beat && w_res_dec) begin
                r_inflight <= r_inflight - 1'b1;
            end
        end
    end

    sha_found_slot u_found_slot (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load_vld (w_hit),
        .i_load_dat (w_res_nonce),
        .i_clr_ovf  (w_job_acc),
        .i_rdy      (i_found_ready),
        .o_vld      (o_found_valid),
        .o_dat      (o_found_nonce),
        .o_ovf      (o_overflow)
    );

    assign o_job_ready     = (r_state == ST_IDLE);
    assign o_busy          = (r_state != ST_IDLE);
    assign o_core_valid    = w_beat;
    assign o_core_newblock = w_newblock;
    assign o_core_nonce    = w_beat ? r_nonce_ctr : '0;

endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// Directed bench: lane A has a 20-beat core model, lanes B/C take hand-driven results.
module tb_sha_nonce_scheduler;

    localparam int LAT = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Lane A: index 0, stride 1
    logic        a_job_valid = 0, a_abort = 0, a_found_ready = 0;
    logic [31:0] a_job_target = 0;
    logic        a_res_valid = 0, a_res_nb = 0;
    logic [31:0] a_res_hash = 0;
    logic        a_job_ready, a_core_valid, a_core_nb, a_found_valid, a_busy, a_ovf;
    logic [31:0] a_core_nonce, a_found_nonce;
    // Lane B: index 2, stride 4
    logic        b_job_valid = 0, b_abort = 0, b_found_ready = 0;
    logic [31:0] b_job_target = 0;
    logic        b_res_valid = 0, b_res_nb = 0;
    logic [31:0] b_res_hash = 0;
    logic        b_job_ready, b_core_valid, b_core_nb, b_found_valid, b_busy, b_ovf;
    logic [31:0] b_core_nonce, b_found_nonce;
    // Lane C: index 0xFFFFFFF0, stride 8
    logic        c_job_valid = 0, c_abort = 0, c_found_ready = 0;
    logic [31:0] c_job_target = 0;
    logic        c_res_valid = 0, c_res_nb = 0;
    logic [31:0] c_res_hash = 0;
    logic        c_job_ready, c_core_valid, c_core_nb, c_found_valid, c_busy, c_ovf;
    logic [31:0] c_core_nonce, c_found_nonce;

    sha_nonce_scheduler #(.PROCESSORINDEX(32'd0), .NUMPROCESSORS(32'd1), .MAX_INFLIGHT(256)) u_a (
        .i_clk(clk), .i_rst(rst), .i_job_valid(a_job_valid), .o_job_ready(a_job_ready),
        .i_job_target(a_job_target), .i_abort(a_abort), .o_core_valid(a_core_valid),
        .o_core_newblock(a_core_nb), .o_core_nonce(a_core_nonce), .i_res_valid(a_res_valid),
        .i_res_newblock(a_res_nb), .i_res_hash_top(a_res_hash), .o_found_valid(a_found_valid),
        .i_found_ready(a_found_ready), .o_found_nonce(a_found_nonce), .o_busy(a_busy),
        .o_overflow(a_ovf));

    sha_nonce_scheduler #(.PROCESSORINDEX(32'd2), .NUMPROCESSORS(32'd4), .MAX_INFLIGHT(256)) u_b (
        .i_clk(clk), .i_rst(rst), .i_job_valid(b_job_valid), .o_job_ready(b_job_ready),
        .i_job_target(b_job_target), .i_abort(b_abort), .o_core_valid(b_core_valid),
        .o_core_newblock(b_core_nb), .o_core_nonce(b_core_nonce), .i_res_valid(b_res_valid),
        .i_res_newblock(b_res_nb), .i_res_hash_top(b_res_hash), .o_found_valid(b_found_valid),
        .i_found_ready(b_found_ready), .o_found_nonce(b_found_nonce), .o_busy(b_busy),
        .o_overflow(b_ovf));

    sha_nonce_scheduler #(.PROCESSORINDEX(32'hFFFFFFF0), .NUMPROCESSORS(32'd8), .MAX_INFLIGHT(256)) u_c (
        .i_clk(clk), .i_rst(rst), .i_job_valid(c_job_valid), .o_job_ready(c_job_ready),
        .i_job_target(c_job_target), .i_abort(c_abort), .o_core_valid(c_core_valid),
        .o_core_newblock(c_core_nb), .o_core_nonce(c_core_nonce), .i_res_valid(c_res_valid),
        .i_res_newblock(c_res_nb), .i_res_hash_top(c_res_hash), .o_found_valid(c_found_valid),
        .i_found_ready(c_found_ready), .o_found_nonce(c_found_nonce), .o_busy(c_busy),
        .o_overflow(c_ovf));

    // Core model for lane A: fixed-latency pipe, hash chosen from the nonce by hash_mode.
    int              hash_mode = 0;
    logic [LAT-1:0]  m_v  = '0;
    logic [LAT-1:0]  m_nb = '0;
    logic [31:0]     m_n [LAT];

    function automatic logic [31:0] model_hash(input int mode, input logic [31:0] n);
        if (mode == 0) return 32'h0;
        if (n == 32'd5) return 32'h10;
        if (n == 32'd6) return 32'h11;
        return 32'hFFFFFFFF;
    endfunction

    always begin
        @(negedge clk);
        #1;
        a_res_valid = m_v[LAT-1];
        a_res_nb    = m_nb[LAT-1];
        a_res_hash  = m_v[LAT-1] ? model_hash(hash_mode, m_n[LAT-1]) : 32'hDEADBEEF;
        for (int i = LAT - 1; i > 0; i--) m_n[i] = m_n[i-1];
        m_n[0] = a_core_nonce;
        m_v    = {m_v[LAT-2:0], a_core_valid};
        m_nb   = {m_nb[LAT-2:0], a_core_nb};
    end

    task automatic a_start(input logic [31:0] tgt);
        @(negedge clk);
        a_job_target = tgt;
        a_job_valid  = 1'b1;
        @(negedge clk);
        a_job_valid  = 1'b0;
    endtask

    task automatic a_abort_drain(input string name);
        bit done = 0;
        @(negedge clk);
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!a_busy) begin done = 1; break; end
        end
        n_tests++;
        if (!done) begin n_fail++; $display("FAIL %s_drain busy never dropped", name); end
    endtask

    task automatic a_clear_slot();
        @(negedge clk);
        a_found_ready = 1'b1;
        @(negedge clk);
        a_found_ready = 1'b0;
        n_tests++;
        if (a_found_valid !== 1'b0) begin n_fail++; $display("FAIL slot_clear found_valid got %b want 0", a_found_valid); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n_tests++; if (a_job_ready !== 1'b1) begin n_fail++; $display("FAIL reset_job_ready got %b want 1", a_job_ready); end
        n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", a_busy); end
        n_tests++; if (a_core_valid !== 1'b0 || a_core_nonce !== 32'h0) begin n_fail++; $display("FAIL reset_core got %b/%h want 0/0", a_core_valid, a_core_nonce); end
        n_tests++; if (a_found_valid !== 1'b0 || a_found_nonce !== 32'h0 || a_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_found got %b/%h/%b want 0/0/0", a_found_valid, a_found_nonce, a_ovf); end
        n_tests++; if (b_job_ready !== 1'b1 || c_job_ready !== 1'b1) begin n_fail++; $display("FAIL reset_bc_ready got %b/%b want 1/1", b_job_ready, c_job_ready); end
    endtask

    // All hashes hit: first winner is nonce 0, the next one overflows the unread slot.
    task automatic test_hits();
        bit seen = 0;
        hash_mode = 0;
        a_start(32'hFFFFFFFF);
        n_tests++; if (a_core_valid !== 1'b1 || a_core_nb !== 1'b1 || a_core_nonce !== 32'd0) begin n_fail++; $display("FAIL hits_first_beat got %b/%b/%h want 1/1/0", a_core_valid, a_core_nb, a_core_nonce); end
        n_tests++; if (a_job_ready !== 1'b0) begin n_fail++; $display("FAIL hits_job_ready got %b want 0", a_job_ready); end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #2;
            if (a_res_valid) begin seen = 1; break; end
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL hits_result_timeout no result within budget"); end
        n_tests++; if (a_found_valid !== 1'b0) begin n_fail++; $display("FAIL hits_pre_found got %b want 0", a_found_valid); end
        @(negedge clk);
        n_tests++; if (a_found_valid !== 1'b1 || a_found_nonce !== 32'd0 || a_ovf !== 1'b0) begin n_fail++; $display("FAIL hits_found got %b/%h/%b want 1/0/0", a_found_valid, a_found_nonce, a_ovf); end
        @(negedge clk);
        n_tests++; if (a_ovf !== 1'b1 || a_found_nonce !== 32'd0) begin n_fail++; $display("FAIL hits_overflow got %b/%h want 1/0", a_ovf, a_found_nonce); end
        a_abort_drain("hits");
        a_clear_slot();
    endtask

    // Only nonce 5 (hash 0x10) meets target 0x10; nonce 6 (0x11) must not register.
    task automatic test_target();
        bit seen = 0;
        hash_mode = 1;
        a_start(32'h10);
        n_tests++; if (a_ovf !== 1'b0) begin n_fail++; $display("FAIL target_ovf_clear got %b want 0", a_ovf); end
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (a_found_valid) begin seen = 1; break; end
        end
        n_tests++;
        if (!seen || a_found_nonce !== 32'd5) begin n_fail++; $display("FAIL target_found got %b/%h want 1/5", a_found_valid, a_found_nonce); end
        repeat (4) @(negedge clk);
        n_tests++; if (a_found_nonce !== 32'd5 || a_ovf !== 1'b0) begin n_fail++; $display("FAIL target_no_0x11 got %h/%b want 5/0", a_found_nonce, a_ovf); end
        a_abort_drain("target");
        a_clear_slot();
    endtask

    // Abort in RUN: no beat that cycle, aborted results never win, idle once all returned.
    task automatic test_abort();
        int  cnt = 0;
        bit  fv = 0;
        bit  done = 0;
        hash_mode = 0;
        a_start(32'hFFFFFFFF);
        repeat (5) @(negedge clk);
        a_abort = 1'b1;
        #1;
        n_tests++; if (a_core_valid !== 1'b0) begin n_fail++; $display("FAIL abort_no_beat got %b want 0", a_core_valid); end
        @(negedge clk);
        a_abort = 1'b0;
        n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL abort_draining got %b want 1", a_busy); end
        for (int i = 0; i < 80; i++) begin
            @(negedge clk); #2;
            if (a_res_valid) cnt++;
            if (a_found_valid) fv = 1;
            if (!a_busy) begin done = 1; break; end
        end
        n_tests++; if (!done) begin n_fail++; $display("FAIL abort_idle busy never dropped"); end
        n_tests++; if (cnt != 5) begin n_fail++; $display("FAIL abort_results got %0d want 5", cnt); end
        n_tests++; if (fv || a_found_valid !== 1'b0) begin n_fail++; $display("FAIL abort_found got %b want 0", fv); end
    endtask

    task automatic test_stride();
        logic [31:0] exp_n [4] = '{32'd2, 32'd6, 32'd10, 32'd14};
        b_job_target = 32'hFFFFFFFF;
        @(negedge clk); b_job_valid = 1'b1;
        @(negedge clk); b_job_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_tests++;
            if (b_core_valid !== 1'b1 || b_core_nb !== (i == 0) || b_core_nonce !== exp_n[i]) begin
                n_fail++; $display("FAIL stride_beat%0d got %b/%b/%h want 1/%0d/%h", i, b_core_valid, b_core_nb, b_core_nonce, (i == 0), exp_n[i]);
            end
        end
        @(negedge clk); b_abort = 1'b1; #1;
        n_tests++; if (b_core_valid !== 1'b0) begin n_fail++; $display("FAIL stride_abort_beat got %b want 0", b_core_valid); end
        @(negedge clk); b_abort = 1'b0;
        b_res_valid = 1'b1; b_res_nb = 1'b1; b_res_hash = 32'h0;
        @(negedge clk); b_res_nb = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk); b_res_valid = 1'b0;
        n_tests++; if (b_busy !== 1'b1) begin n_fail++; $display("FAIL stride_busy_last got %b want 1", b_busy); end
        @(negedge clk);
        n_tests++; if (b_busy !== 1'b0 || b_found_valid !== 1'b0) begin n_fail++; $display("FAIL stride_idle got %b/%b want 0/0", b_busy, b_found_valid); end
    endtask

    task automatic test_wrap();
        c_job_target = 32'h100;
        @(negedge clk); c_job_valid = 1'b1;
        @(negedge clk); c_job_valid = 1'b0;
        n_tests++; if (c_core_valid !== 1'b1 || c_core_nb !== 1'b1 || c_core_nonce !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL wrap_beat0 got %b/%b/%h want 1/1/fffffff0", c_core_valid, c_core_nb, c_core_nonce); end
        @(negedge clk);
        n_tests++; if (c_core_valid !== 1'b1 || c_core_nb !== 1'b0 || c_core_nonce !== 32'hFFFFFFF8) begin n_fail++; $display("FAIL wrap_beat1 got %b/%b/%h want 1/0/fffffff8", c_core_valid, c_core_nb, c_core_nonce); end
        @(negedge clk);
        n_tests++; if (c_core_valid !== 1'b0 || c_busy !== 1'b1) begin n_fail++; $display("FAIL wrap_drain got %b/%b want 0/1", c_core_valid, c_busy); end
        c_res_valid = 1'b1; c_res_nb = 1'b1; c_res_hash = 32'hFFFFFFFF;
        @(negedge clk);
        n_tests++; if (c_busy !== 1'b1 || c_found_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_mid got %b/%b want 1/0", c_busy, c_found_valid); end
        c_res_nb = 1'b0; c_res_hash = 32'h5;
        @(negedge clk);
        c_res_valid = 1'b0;
        n_tests++; if (c_found_valid !== 1'b1 || c_found_nonce !== 32'hFFFFFFF8 || c_busy !== 1'b1) begin n_fail++; $display("FAIL wrap_found got %b/%h/%b want 1/fffffff8/1", c_found_valid, c_found_nonce, c_busy); end
        @(negedge clk);
        n_tests++; if (c_busy !== 1'b0) begin n_fail++; $display("FAIL wrap_idle got %b want 0", c_busy); end
    endtask

    task automatic test_mid_reset();
        bit bad = 0;
        hash_mode = 0;
        a_start(32'hFFFFFFFF);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_tests++; if (a_job_ready !== 1'b1 || a_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_state got %b/%b want 1/0", a_job_ready, a_busy); end
        n_tests++; if (a_core_valid !== 1'b0 || a_core_nonce !== 32'h0) begin n_fail++; $display("FAIL midrst_core got %b/%h want 0/0", a_core_valid, a_core_nonce); end
        n_tests++; if (a_found_valid !== 1'b0 || a_ovf !== 1'b0 || a_found_nonce !== 32'h0) begin n_fail++; $display("FAIL midrst_found got %b/%b/%h want 0/0/0", a_found_valid, a_ovf, a_found_nonce); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_found_valid || a_busy) bad = 1;
        end
        n_tests++; if (bad) begin n_fail++; $display("FAIL midrst_stale got found/busy activity want none"); end
    endtask

    initial begin
        test_reset();
        test_hits();
        test_target();
        test_abort();
        test_stride();
        test_wrap();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
